// File: rtl/exec_trace_pkg.sv
// exec_trace_pkg
// Shared types and constants for the execution trace monitor.
//   state_t        : monitor FSM states
//   KIND_REG/STORE : record kind bit
//   TS_W           : width of the optional trailing timestamp field
//   rec_width()    : width of one packed trace record
// Build option: TRACE_TIMESTAMP_EN appends cycle_count[15:0] to each record.
package exec_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_HALTED    = 2'd2,
      ST_TIMED_OUT = 2'd3
   } state_t;

   localparam logic KIND_REG   = 1'b0;
   localparam logic KIND_STORE = 1'b1;
   localparam int   TS_W       = 16;

`ifdef TRACE_TIMESTAMP_EN
   localparam int TS_EXTRA_W = TS_W;
`else
   localparam int TS_EXTRA_W = 0;
`endif

   // {kind, addr, data[, timestamp]}
   function automatic int rec_width(input int daddr_w, input int data_w);
      return 1 + daddr_w + data_w + TS_EXTRA_W;
   endfunction

endpackage

// File: rtl/trace_fifo_dual_push.sv
// trace_fifo_dual_push
// FIFO accepting up to two pushes (a then b) and one pop per cycle.
// Ports:
//   clock, reset           : clock, asynchronous active-low reset
//   push_a/data_a          : first write of the cycle
//   push_b/data_b          : second write, honoured only together with push_a
//   pop                    : remove head (ignored when empty)
//   head_data, head_valid  : current head (zero while empty)
//   free_count             : free slots before this cycle's pop/push
// The caller must never push more entries than free_count + pop.
module trace_fifo_dual_push #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_a,
   input  logic [WIDTH-1:0]         data_a,
   input  logic                     push_b,
   input  logic [WIDTH-1:0]         data_b,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   free_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0]   PTR_TWO = (AW+1)'(2);
   localparam logic [AW-1:0] IDX_ONE = AW'(1);
   localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
   logic [AW-1:0]    wr_idx_a, wr_idx_b;
   logic             empty, full;

   assign wr_idx_a = wr_ptr_reg[AW-1:0];
   assign wr_idx_b = wr_idx_a + IDX_ONE;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   assign free_count = full ? '0 : (DEPTH_V - (wr_ptr_reg - rd_ptr_reg));
   assign head_valid = !empty;
   assign head_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (pop && !empty)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (push_a && push_b)
            wr_ptr_reg <= wr_ptr_reg + PTR_TWO;
         else if (push_a)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push_a)
         mem[wr_idx_a] <= data_a;
      if (push_a && push_b)
         mem[wr_idx_b] <= data_b;
   end

endmodule

// File: rtl/exec_trace_monitor.sv
// exec_trace_monitor
// Snoops the register-file write port and dmem store port, packs events into
// trace records, buffers them and drains them over a valid/ready stream.
// Also flags program halt (PC stuck) and run timeout.
// Ports:
//   clock, reset (async, active-low), enable (arm monitor), pc
//   wren/address_dmem/data        : dmem store port
//   rf_we/rf_waddr/rf_wdata       : register-file write port
//   trace_valid/trace_ready/trace_data : record stream {kind, addr, data[, ts]}
//   halted, timed_out             : level status flags
//   cycle_count, drop_count       : RUN cycles, records lost (saturating)
// Build option: TRACE_TIMESTAMP_EN adds cycle_count[15:0] to every record.
module exec_trace_monitor
   import exec_trace_pkg::*;
#(
   parameter int PC_W           = 12,
   parameter int DADDR_W        = 12,
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 16,
   parameter int HALT_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 50
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     enable,
   input  logic [PC_W-1:0]                          pc,
   input  logic                                     wren,
   input  logic [DADDR_W-1:0]                       address_dmem,
   input  logic [DATA_W-1:0]                        data,
   input  logic                                     rf_we,
   input  logic [4:0]                               rf_waddr,
   input  logic [DATA_W-1:0]                        rf_wdata,
   output logic                                     trace_valid,
   input  logic                                     trace_ready,
   output logic [rec_width(DADDR_W, DATA_W)-1:0]    trace_data,
   output logic                                     halted,
   output logic                                     timed_out,
   output logic [31:0]                              cycle_count,
   output logic [15:0]                              drop_count
);

   localparam int REC_W   = rec_width(DADDR_W, DATA_W);
   localparam int AW      = $clog2(DEPTH);
   localparam int STALL_W = $clog2(HALT_CYCLES + 1);
   localparam logic [AW+1:0] AVAIL_ONE = (AW+2)'(1);
   localparam logic [AW+1:0] AVAIL_TWO = (AW+2)'(2);

   state_t             state_reg, state_next;
   logic [PC_W-1:0]    pc_prev_reg;
   logic [STALL_W-1:0] stall_reg;
   logic [31:0]        cycle_reg;
   logic [15:0]        drop_reg;

   logic               in_run, start, pc_same, halt_hit, timeout_hit;
   logic               store_ev, reg_ev, pop;
   logic [AW:0]        free_count;
   logic [AW+1:0]      avail;
   logic               push_a, push_b;
   logic [REC_W-1:0]   data_a, store_rec, reg_rec;
   logic [1:0]         drops;
   logic [16:0]        drop_sum;
   logic [15:0]        drop_sat;

   assign in_run      = (state_reg == ST_RUN);
   assign start       = (state_reg == ST_IDLE) && enable;
   assign pc_same     = (pc == pc_prev_reg);
   assign halt_hit    = in_run && pc_same && (stall_reg == STALL_W'(HALT_CYCLES - 1));
   assign timeout_hit = in_run && (cycle_reg == 32'(TIMEOUT_CYCLES - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (!enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN: begin
               // Halt takes priority over a coincident timeout.
               if (halt_hit)
                  state_next = ST_HALTED;
               else if (timeout_hit)
                  state_next = ST_TIMED_OUT;
            end
            default: state_next = state_reg;
         endcase
      end
   end

   // ---------------- record packing / push arbitration ----------------
`ifdef TRACE_TIMESTAMP_EN
   assign store_rec = {KIND_STORE, address_dmem, data, cycle_reg[TS_W-1:0]};
   assign reg_rec   = {KIND_REG, DADDR_W'(rf_waddr), rf_wdata, cycle_reg[TS_W-1:0]};
`else
   assign store_rec = {KIND_STORE, address_dmem, data};
   assign reg_rec   = {KIND_REG, DADDR_W'(rf_waddr), rf_wdata};
`endif

   assign store_ev = in_run && wren;
   assign reg_ev   = in_run && rf_we && (rf_waddr != 5'd0);
   assign pop      = trace_valid && trace_ready;

   // A same-cycle pop frees its slot before we decide what fits.
   assign avail = {1'b0, free_count} + {{(AW+1){1'b0}}, pop};

   always_comb begin
      push_a = 1'b0;
      push_b = 1'b0;
      data_a = store_rec;
      drops  = 2'd0;
      if (store_ev && reg_ev) begin
         if (avail >= AVAIL_TWO) begin
            push_a = 1'b1;
            push_b = 1'b1;
         end else if (avail == AVAIL_ONE) begin
            push_a = 1'b1;
            drops  = 2'd1;
         end else begin
            drops  = 2'd2;
         end
      end else if (store_ev || reg_ev) begin
         data_a = store_ev ? store_rec : reg_rec;
         if (avail != '0)
            push_a = 1'b1;
         else
            drops = 2'd1;
      end
   end

   assign drop_sum = {1'b0, drop_reg} + {15'd0, drops};
   assign drop_sat = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   // ---------------- counters ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_prev_reg <= '0;
         stall_reg   <= '0;
         cycle_reg   <= '0;
         drop_reg    <= '0;
      end else begin
         pc_prev_reg <= pc;
         if (start) begin
            stall_reg <= '0;
            cycle_reg <= '0;
            drop_reg  <= '0;
         end else if (in_run) begin
            cycle_reg <= cycle_reg + 32'd1;
            stall_reg <= pc_same ? stall_reg + STALL_W'(1) : '0;
            drop_reg  <= drop_sat;
         end
      end
   end

   trace_fifo_dual_push #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_a     (push_a),
      .data_a     (data_a),
      .push_b     (push_b),
      .data_b     (reg_rec),
      .pop        (pop),
      .head_data  (trace_data),
      .head_valid (trace_valid),
      .free_count (free_count)
   );

   assign halted      = (state_reg == ST_HALTED);
   assign timed_out   = (state_reg == ST_TIMED_OUT);
   assign cycle_count = cycle_reg;
   assign drop_count  = drop_reg;

endmodule
